// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
// Used by the result buffer and the flag generator.
package alu_pkg;
  localparam int ALU_W = 32;

  typedef logic [2:0] op_t;

  typedef struct packed {
    logic [ALU_W:0] res;
    op_t            op;
    logic           z;
    logic           c;
    logic           n;
  } alu_entry_t;

  localparam op_t OP_SEL0 = 3'b000;
  localparam op_t OP_SEL1 = 3'b001;
  localparam op_t OP_SEL2 = 3'b010;
  localparam op_t OP_SEL3 = 3'b011;
  localparam op_t OP_SEL4 = 3'b100;
  localparam op_t OP_SEL5 = 3'b101;
  localparam op_t OP_SEL6 = 3'b110;
  localparam op_t OP_SEL7 = 3'b111;
endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags from a carry-extended ALU result.
// Zero looks only at the data bits; the carry bit is excluded.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic [DATA_W:0] i_res,
  output logic            o_z,
  output logic            o_c,
  output logic            o_n
);
  assign o_z = (i_res[DATA_W-1:0] == '0);
  assign o_c = i_res[DATA_W];
  assign o_n = i_res[DATA_W-1];
endmodule

// File: rtl/alu_res_buffer.sv
// ALU result FIFO with flags and valid/ready output handshake.
// Optional push/carry statistics counters under ALU_RES_STATS_EN.
module alu_res_buffer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W:0]          res,
  input  logic                     s2,
  input  logic                     s1,
  input  logic                     s0,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W:0]          out_res,
  output logic [2:0]               out_op,
  output logic                     out_z,
  output logic                     out_c,
  output logic                     out_n,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RES_STATS_EN
  ,
  output logic [15:0]              carry_cnt,
  output logic [15:0]              push_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W:0] res;
    op_t             op;
    logic            z;
    logic            c;
    logic            n;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic            w_push;
  logic            w_pop;
  logic [DATA_W:0] w_res;
  logic            w_z;
  logic            w_c;
  logic            w_n;
  entry_t          w_head;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Idle-cycle X on res must never reach the flag logic.
  assign w_res = in_valid ? res : '0;

  alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .i_res (w_res),
    .o_z   (w_z),
    .o_c   (w_c),
    .o_n   (w_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= '{res: w_res, op: {s2, s1, s0}, z: w_z, c: w_c, n: w_n};
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign out_res = out_valid ? w_head.res : '0;
  assign out_op  = out_valid ? w_head.op  : '0;
  assign out_z   = out_valid & w_head.z;
  assign out_c   = out_valid & w_head.c;
  assign out_n   = out_valid & w_head.n;
  assign count   = r_count;

`ifdef ALU_RES_STATS_EN
  logic [15:0] r_carry_cnt;
  logic [15:0] r_push_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_cnt <= '0;
      r_push_cnt  <= '0;
    end else if (w_push) begin
      r_push_cnt <= r_push_cnt + 16'd1;
      if (w_c && (r_carry_cnt != 16'hFFFF)) r_carry_cnt <= r_carry_cnt + 16'd1;
    end
  end

  assign carry_cnt = r_carry_cnt;
  assign push_cnt  = r_push_cnt;
`endif
endmodule

// File: tb/tb_alu_res_buffer.sv
// Scoreboard bench for alu_res_buffer: expected entries are queued on
// accepted pushes and compared against the head on accepted pops.
module tb_alu_res_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [DATA_W:0] res;
    logic [2:0]      op;
    logic            z;
    logic            c;
    logic            n;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W:0]   res = '0;
  logic              s2 = 1'b0, s1 = 1'b0, s0 = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W:0]   out_res;
  logic [2:0]        out_op;
  logic              out_z, out_c, out_n;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_RES_STATS_EN
  logic [15:0]       carry_cnt, push_cnt;
  int                m_push = 0, m_carry = 0;
`endif

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   seen_rst = 1'b0;

  alu_res_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_op    (out_op),
    .out_z     (out_z),
    .out_c     (out_c),
    .out_n     (out_n),
    .count     (count)
`ifdef ALU_RES_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .push_cnt  (push_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      seen_rst = 1'b1;
`ifdef ALU_RES_STATS_EN
      m_push  = 0;
      m_carry = 0;
`endif
    end else if (seen_rst) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() == 0) begin
        chk("empty_res", 64'(out_res), 64'd0);
        chk("empty_flags", 64'({out_op, out_z, out_c, out_n}), 64'd0);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_res", 64'(out_res), 64'(e.res));
        chk("out_op", 64'(out_op), 64'(e.op));
        chk("out_z", 64'(out_z), 64'(e.z));
        chk("out_c", 64'(out_c), 64'(e.c));
        chk("out_n", 64'(out_n), 64'(e.n));
      end
      if (in_valid && in_ready) begin
        e.res = res;
        e.op  = {s2, s1, s0};
        e.z   = (res[DATA_W-1:0] == 0);
        e.c   = res[DATA_W];
        e.n   = res[DATA_W-1];
        q.push_back(e);
`ifdef ALU_RES_STATS_EN
        m_push++;
        if (res[DATA_W]) m_carry++;
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DATA_W:0] r, input logic [2:0] op);
    bit ok = 1'b0;
    in_valid = 1'b1;
    res = r;
    {s2, s1, s0} = op;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    res = 'x;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (count == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;

    // Single entry with zero data and carry set
    send(33'h1_0000_0000, 3'b000);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_flags", 64'({out_z, out_c, out_n}), 64'b110);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("one_cnt", 64'(count), 64'd0);

    // Fill to full, hold a fifth entry, release one slot
    send(33'h0_8000_0001, 3'b001);
    send(33'h0_0000_0005, 3'b010);
    send(33'h1_FFFF_FFFF, 3'b011);
    send(33'h0_0000_0000, 3'b100);
    chk("full_cnt", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    res = 33'h0_0000_00AA;
    {s2, s1, s0} = 3'b101;
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_cnt", 64'(count), 64'd4);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("slot_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    res = 'x;
    chk("refill_cnt", 64'(count), 64'd4);
    drain();

    // Streaming push+pop, op cycling, pointers wrapping
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      res = 33'(32'h1000 + i * 32'h0111_0001);
      {s2, s1, s0} = 3'(i % 8);
      @(posedge clk); #1;
      chk("stream_cnt", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    res = 'x;
    drain();

    // Reset with entries buffered
    send(33'h0_0000_0011, 3'b110);
    send(33'h1_0000_0022, 3'b111);
    send(33'h0_FFFF_0033, 3'b001);
    chk("pre_rst_cnt", 64'(count), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    send(33'h0_0000_0007, 3'b010);
    chk("post_rst_res", 64'(out_res), 64'h7);
    drain();

`ifdef ALU_RES_STATS_EN
    chk("push_cnt", 64'(push_cnt), 64'(m_push));
    chk("carry_cnt", 64'(carry_cnt), 64'(m_carry));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(33'h1_0000_0001, 3'b000);
    send(33'h0_0000_0002, 3'b001);
    send(33'h1_0000_0003, 3'b010);
    send(33'h0_0000_0004, 3'b011);
    drain();
    send(33'h0_0000_0005, 3'b100);
    drain();
    chk("stats_push", 64'(push_cnt), 64'd5);
    chk("stats_carry", 64'(carry_cnt), 64'd2);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
